// File: rtl/inst_rom_pkg.sv
// inst_rom_pkg
//   Shared types and constants for the instruction ROM and its program loader.
//   Also carries the shared fetch-bus defines used across the SoC.
//   No ports; imported by inst_rom and inst_rom_loader.

`ifndef INST_ROM_DEFINES
`define INST_ROM_DEFINES
`define INST_ADDR_BUS   31:0
`define INST_BUS        31:0
`define ZERO_WORD       32'h00000000
`define CHIP_ENABLE     1'b1
`define CHIP_DISABLE    1'b0
`define RST_ENABLE      1'b1
`define INST_ROM_ADDR_W 10
`endif

package inst_rom_pkg;

  // Loader session states. The core is only released while in LOAD_DONE.
  typedef enum logic [1:0] {
    LOAD_IDLE = 2'd0,
    LOAD_BUSY = 2'd1,
    LOAD_DONE = 2'd2
  } load_state_e;

  // Index of the last byte of a big-endian word within the assembler.
  localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

  // Word returned for disabled or out-of-range fetches (decodes as a NOP).
  localparam logic [31:0] NOP_WORD = `ZERO_WORD;

endpackage

// File: rtl/inst_rom_loader.sv
// inst_rom_loader
//   Byte-serial program loader. Assembles big-endian bytes into 32-bit words,
//   emits one memory write per completed word and holds the core in reset
//   until the requested number of words has been written.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load_start_i    begin a session (honoured only outside an active load)
//   load_len_i      number of words to load, sampled with load_start_i
//   ld_valid_i      byte strobe from the host
//   ld_byte_i       byte data
//   ld_ready_o      loader can accept a byte this cycle
//   load_done_o     session completed
//   ld_err_o        sticky oversize-length flag
//   core_rst_o      registered reset for the CPU core
//   we, waddr, wdata  word write port toward the memory array

module inst_rom_loader
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = `INST_ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  output logic              ld_ready_o,
  output logic              load_done_o,
  output logic              ld_err_o,
  output logic              core_rst_o,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata
);

  localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};

  load_state_e       state_q, state_d;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W:0]   len_q;
  logic [23:0]       buf_q;
  logic              err_q;
  logic              core_rst_q;

  logic            accept;
  logic            word_done;
  logic            last_word;
  logic            start_seen;
  logic            len_over;
  logic            len_zero;
  logic [ADDR_W:0] word_cnt_inc;

  // Handshake and session-start decode. A start request only counts outside
  // an active load; oversize lengths are flagged and never start a session.
  always_comb begin
    accept       = (state_q == LOAD_BUSY) && ld_valid_i;
    word_done    = accept && (byte_cnt_q == LAST_BYTE_IDX);
    word_cnt_inc = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    last_word    = word_done && (word_cnt_inc == len_q);
    start_seen   = load_start_i && (state_q != LOAD_BUSY);
    len_over     = load_len_i > DEPTH_LEN;
    len_zero     = (load_len_i == '0);
  end

  // Next-state logic. A zero-length request completes immediately without
  // touching memory; a valid nonzero request (re)enters the loading state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD_IDLE, LOAD_DONE: begin
        if (start_seen && !len_over) begin
          state_d = len_zero ? LOAD_DONE : LOAD_BUSY;
        end
      end
      LOAD_BUSY: begin
        if (last_word) begin
          state_d = LOAD_DONE;
        end
      end
      default: state_d = LOAD_IDLE;
    endcase
  end

  // State, counters and byte assembler. core_rst is registered from the next
  // state so it drops in the first cycle spent in LOAD_DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD_IDLE;
      byte_cnt_q <= '0;
      waddr_q    <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      buf_q      <= '0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      core_rst_q <= (state_d != LOAD_DONE);
      if (start_seen && len_over) begin
        err_q <= 1'b1;
      end else if (start_seen && !len_zero) begin
        len_q      <= load_len_i;
        byte_cnt_q <= '0;
        waddr_q    <= '0;
        word_cnt_q <= '0;
        buf_q      <= '0;
        err_q      <= 1'b0;
      end
      if (accept) begin
        buf_q      <= {buf_q[15:0], ld_byte_i};
        byte_cnt_q <= byte_cnt_q + 2'd1;
        if (word_done) begin
          waddr_q    <= waddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          word_cnt_q <= word_cnt_inc;
        end
      end
    end
  end

  always_comb begin
    ld_ready_o  = (state_q == LOAD_BUSY);
    load_done_o = (state_q == LOAD_DONE);
    ld_err_o    = err_q;
    core_rst_o  = core_rst_q;
    we          = word_done;
    waddr       = waddr_q;
    wdata       = {buf_q, ld_byte_i};
  end

endmodule

// File: rtl/inst_rom.sv
// inst_rom
//   Instruction memory on the core fetch interface with a zero-wait
//   combinational read port, plus a byte-serial loader that fills the array
//   after reset and keeps the core in reset until loading completes.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   rom_ce_i        fetch chip enable
//   rom_addr_i      fetch byte address
//   rom_data_o      instruction word (zero when disabled or out of range)
//   load_start_i, load_len_i, ld_valid_i, ld_byte_i, ld_ready_o,
//   load_done_o, ld_err_o, core_rst_o   loader interface (see inst_rom_loader)

module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = `INST_ROM_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rom_ce_i,
  input  logic [`INST_ADDR_BUS] rom_addr_i,
  output logic [`INST_BUS] rom_data_o,
  input  logic             load_start_i,
  input  logic [ADDR_W:0]  load_len_i,
  input  logic             ld_valid_i,
  input  logic [7:0]       ld_byte_i,
  output logic             ld_ready_o,
  output logic             load_done_o,
  output logic             ld_err_o,
  output logic             core_rst_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] word_idx;
  logic              addr_out_of_range;
  logic              unused_addr_bits;

  inst_rom_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start_i),
    .load_len_i   (load_len_i),
    .ld_valid_i   (ld_valid_i),
    .ld_byte_i    (ld_byte_i),
    .ld_ready_o   (ld_ready_o),
    .load_done_o  (load_done_o),
    .ld_err_o     (ld_err_o),
    .core_rst_o   (core_rst_o),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata)
  );

  // Array contents are deliberately not reset so a reset mid-load keeps the
  // words already written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational fetch. The array is read before the write edge, so a fetch
  // of the word being written sees the old contents. Byte-offset bits are
  // ignored; any address beyond the array returns a NOP.
  always_comb begin
    word_idx          = rom_addr_i[ADDR_W+1:2];
    addr_out_of_range = |(rom_addr_i >> (ADDR_W + 2));
    unused_addr_bits  = ^rom_addr_i[1:0];
    rom_data_o        = NOP_WORD;
    if (rom_ce_i == `CHIP_ENABLE && !addr_out_of_range) begin
      rom_data_o = mem[word_idx];
    end
  end

endmodule

// File: tb/tb_inst_rom.sv
// tb_inst_rom
//   Directed testbench for inst_rom (ADDR_W = 10). Each task covers one
//   scenario and checks DUT outputs against hand-computed values.

module tb_inst_rom;

  logic        clk;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        load_start_i;
  logic [10:0] load_len_i;
  logic        ld_valid_i;
  logic [7:0]  ld_byte_i;
  logic        ld_ready_o;
  logic        load_done_o;
  logic        ld_err_o;
  logic        core_rst_o;

  int checks;
  int errors;

  inst_rom #(.ADDR_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .load_start_i (load_start_i),
    .load_len_i   (load_len_i),
    .ld_valid_i   (ld_valid_i),
    .ld_byte_i    (ld_byte_i),
    .ld_ready_o   (ld_ready_o),
    .load_done_o  (load_done_o),
    .ld_err_o     (ld_err_o),
    .core_rst_o   (core_rst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic start_load(input logic [10:0] len);
    load_start_i = 1'b1;
    load_len_i   = len;
    step();
    load_start_i = 1'b0;
  endtask

  // Present one byte and hold it until the edge at which it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited     = 0;
    ld_valid_i = 1'b1;
    ld_byte_i  = b;
    while (!ld_ready_o && waited < 50) begin
      step();
      waited++;
    end
    if (!ld_ready_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout byte=%02h ready=%0b expected 1", b, ld_ready_o);
    end
    step();
    ld_valid_i = 1'b0;
  endtask

  task automatic fetch(input logic ce, input logic [31:0] addr, output logic [31:0] data);
    rom_ce_i   = ce;
    rom_addr_i = addr;
    #1;
    data = rom_data_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++;
    if (ld_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got=%0b exp=0", ld_ready_o); end
    checks++;
    if (load_done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b exp=0", load_done_o); end
    checks++;
    if (ld_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%0b exp=0", ld_err_o); end
    checks++;
    if (core_rst_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_core_rst got=%0b exp=1", core_rst_o); end
    fetch(1'b0, 32'h0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_ce_off got=%08h exp=00000000", d); end
  endtask

  task automatic test_two_word_load();
    logic [7:0]  bytes [8] = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
    logic [31:0] d;
    start_load(11'd2);
    checks++;
    if (ld_ready_o !== 1'b1 || core_rst_o !== 1'b1) begin
      errors++; $display("[TB] FAIL load_enter ready=%0b core_rst=%0b exp=1,1", ld_ready_o, core_rst_o);
    end
    for (int i = 0; i < 7; i++) send_byte(bytes[i]);
    checks++;
    if (load_done_o !== 1'b0 || core_rst_o !== 1'b1) begin
      errors++; $display("[TB] FAIL load_early_done done=%0b core_rst=%0b exp=0,1", load_done_o, core_rst_o);
    end
    send_byte(bytes[7]);
    checks++;
    if (load_done_o !== 1'b1 || core_rst_o !== 1'b0 || ld_ready_o !== 1'b0) begin
      errors++; $display("[TB] FAIL load_finish done=%0b core_rst=%0b ready=%0b exp=1,0,0",
                         load_done_o, core_rst_o, ld_ready_o);
    end
    fetch(1'b1, 32'h0, d);
    checks++;
    if (d !== 32'h34011100) begin errors++; $display("[TB] FAIL load_mem0 got=%08h exp=34011100", d); end
    fetch(1'b1, 32'h4, d);
    checks++;
    if (d !== 32'h34020020) begin errors++; $display("[TB] FAIL load_mem1 got=%08h exp=34020020", d); end
  endtask

  task automatic test_fetch();
    logic [31:0] d;
    fetch(1'b1, 32'h00000007, d);
    checks++;
    if (d !== 32'h34020020) begin errors++; $display("[TB] FAIL fetch_low_bits got=%08h exp=34020020", d); end
    fetch(1'b1, 32'h00001000, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL fetch_range got=%08h exp=00000000", d); end
    fetch(1'b1, 32'h80000004, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL fetch_top_bit got=%08h exp=00000000", d); end
    fetch(1'b1, 32'h00000FFC, d);
    fetch(1'b0, 32'h00000000, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL fetch_ce_off got=%08h exp=00000000", d); end
  endtask

  task automatic test_back_pressure();
    logic [7:0]  bytes [8] = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
    logic [31:0] d;
    // Bytes offered while not ready (still in DONE) must be dropped.
    ld_valid_i = 1'b1;
    ld_byte_i  = 8'hFF;
    step();
    step();
    start_load(11'd2);
    ld_valid_i = 1'b0;
    checks++;
    if (core_rst_o !== 1'b1 || load_done_o !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_enter core_rst=%0b done=%0b exp=1,0", core_rst_o, load_done_o);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        checks++;
        if (load_done_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_early_done got=%0b exp=0", load_done_o); end
      end
      send_byte(bytes[i]);
      if (i != 7) begin
        step(); step(); step();
      end
    end
    checks++;
    if (load_done_o !== 1'b1 || core_rst_o !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_done done=%0b core_rst=%0b exp=1,0", load_done_o, core_rst_o);
    end
    fetch(1'b1, 32'h0, d);
    checks++;
    if (d !== 32'h34011100) begin errors++; $display("[TB] FAIL bp_mem0 got=%08h exp=34011100", d); end
    fetch(1'b1, 32'h4, d);
    checks++;
    if (d !== 32'h34020020) begin errors++; $display("[TB] FAIL bp_mem1 got=%08h exp=34020020", d); end
  endtask

  task automatic test_lengths();
    logic [31:0] d;
    do_reset();
    start_load(11'd0);
    checks++;
    if (load_done_o !== 1'b1 || core_rst_o !== 1'b0) begin
      errors++; $display("[TB] FAIL len0_done done=%0b core_rst=%0b exp=1,0", load_done_o, core_rst_o);
    end
    fetch(1'b1, 32'h0, d);
    checks++;
    if (d !== 32'h34011100) begin errors++; $display("[TB] FAIL len0_nowrite got=%08h exp=34011100", d); end
    do_reset();
    start_load(11'd1025);
    checks++;
    if (ld_err_o !== 1'b1 || ld_ready_o !== 1'b0 || load_done_o !== 1'b0 || core_rst_o !== 1'b1) begin
      errors++; $display("[TB] FAIL len_over err=%0b ready=%0b done=%0b core_rst=%0b exp=1,0,0,1",
                         ld_err_o, ld_ready_o, load_done_o, core_rst_o);
    end
    step();
    checks++;
    if (ld_err_o !== 1'b1) begin errors++; $display("[TB] FAIL len_over_sticky got=%0b exp=1", ld_err_o); end
    start_load(11'd1);
    checks++;
    if (ld_err_o !== 1'b0 || ld_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL len1_clear err=%0b ready=%0b exp=0,1", ld_err_o, ld_ready_o);
    end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    fetch(1'b1, 32'h0, d);
    checks++;
    if (d !== 32'h01020304 || load_done_o !== 1'b1) begin
      errors++; $display("[TB] FAIL len1_word got=%08h done=%0b exp=01020304,1", d, load_done_o);
    end
    // The full depth is a legal length.
    do_reset();
    start_load(11'd1024);
    checks++;
    if (ld_err_o !== 1'b0 || ld_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL len_max err=%0b ready=%0b exp=0,1", ld_err_o, ld_ready_o);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] d;
    do_reset();
    start_load(11'd2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    do_reset();
    checks++;
    if (ld_ready_o !== 1'b0 || load_done_o !== 1'b0 || core_rst_o !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_state ready=%0b done=%0b core_rst=%0b exp=0,0,1",
                         ld_ready_o, load_done_o, core_rst_o);
    end
    fetch(1'b1, 32'h0, d);
    checks++;
    if (d !== 32'h11223344) begin errors++; $display("[TB] FAIL midrst_mem0 got=%08h exp=11223344", d); end
    fetch(1'b1, 32'h4, d);
    checks++;
    if (d !== 32'h34020020) begin errors++; $display("[TB] FAIL midrst_mem1 got=%08h exp=34020020", d); end
    start_load(11'd1);
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h99); send_byte(8'hAA);
    fetch(1'b1, 32'h0, d);
    checks++;
    if (d !== 32'h778899AA) begin errors++; $display("[TB] FAIL midrst_fresh got=%08h exp=778899AA", d); end
    fetch(1'b1, 32'h4, d);
    checks++;
    if (d !== 32'h34020020) begin errors++; $display("[TB] FAIL midrst_fresh_mem1 got=%08h exp=34020020", d); end
  endtask

  task automatic test_reload_from_done();
    logic [31:0] d;
    checks++;
    if (load_done_o !== 1'b1) begin errors++; $display("[TB] FAIL reload_pre_done got=%0b exp=1", load_done_o); end
    start_load(11'd1);
    checks++;
    if (core_rst_o !== 1'b1 || load_done_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reload_core_rst core_rst=%0b done=%0b exp=1,0", core_rst_o, load_done_o);
    end
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    // Fetch of the word being written during the write cycle shows old data.
    ld_valid_i = 1'b1;
    ld_byte_i  = 8'hDD;
    fetch(1'b1, 32'h0, d);
    checks++;
    if (d !== 32'h778899AA) begin errors++; $display("[TB] FAIL reload_rdw got=%08h exp=778899AA", d); end
    step();
    ld_valid_i = 1'b0;
    fetch(1'b1, 32'h0, d);
    checks++;
    if (d !== 32'hAABBCCDD) begin errors++; $display("[TB] FAIL reload_mem0 got=%08h exp=AABBCCDD", d); end
    fetch(1'b1, 32'h4, d);
    checks++;
    if (d !== 32'h34020020) begin errors++; $display("[TB] FAIL reload_mem1 got=%08h exp=34020020", d); end
    checks++;
    if (load_done_o !== 1'b1 || core_rst_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reload_done done=%0b core_rst=%0b exp=1,0", load_done_o, core_rst_o);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    rom_ce_i     = 1'b0;
    rom_addr_i   = 32'h0;
    load_start_i = 1'b0;
    load_len_i   = '0;
    ld_valid_i   = 1'b0;
    ld_byte_i    = 8'h00;
    step();
    test_reset();
    test_two_word_load();
    test_fetch();
    test_back_pressure();
    test_lengths();
    test_reset_mid_load();
    test_reload_from_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
